pu_datapath_nested: RTL

//  Parametrised second-generation Gumnut-style processing datapath: register bank, operand
//  mux, ALU with registered result, C/Z condition flags and registered I/O-port write path.

---
 rtl/pu_datapath_nested.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/pu_datapath_nested.sv
// Gumnut-style processing datapath: register bank, ALU with registered result, C/Z flags,
// registered port write path and a shadow stack that saves/restores flags across nested interrupts.
module pu_datapath_nested #(
  parameter  int DATA_W     = 8,
  parameter  int NREGS      = 8,
  parameter  int FLAG_DEPTH = 4,
  localparam int RSEL_W     = $clog2(NREGS),
  localparam int DEPTH_W    = $clog2(FLAG_DEPTH + 1),
  localparam int CNT_W      = $clog2(DATA_W)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cen_i,
  input  logic [RSEL_W-1:0]  rs_i,
  input  logic [RSEL_W-1:0]  rs2_i,
  input  logic [RSEL_W-1:0]  rd_i,
  input  logic               dp_sel_i,
  input  logic [DATA_W-1:0]  immed_i,
  input  logic [CNT_W-1:0]   count_i,
  input  logic               op2_sel_i,
  input  logic [3:0]         alu_op_i,
  input  logic               alu_en_i,
  input  logic               flag_we_i,
  input  logic               reg_we_i,
  input  logic [1:0]         reg_mux_i,
  input  logic [DATA_W-1:0]  data_dat_i,
  input  logic [DATA_W-1:0]  port_dat_i,
  input  logic               port_we_i,
  input  logic               int_entry_i,
  input  logic               reti_i,
  output logic [DATA_W-1:0]  data_addr_o,
  output logic [DATA_W-1:0]  data_wdat_o,
  output logic               port_we_o,
  output logic [DATA_W-1:0]  port_addr_o,
  output logic [DATA_W-1:0]  port_dat_o,
  output logic               cc_c_o,
  output logic               cc_z_o,
  output logic [DEPTH_W-1:0] stk_depth_o,
  output logic               stk_err_o
);

  localparam int IDX_W = (FLAG_DEPTH > 1) ? $clog2(FLAG_DEPTH) : 1;

  logic [DATA_W-1:0]  regs [NREGS];
  logic [DATA_W-1:0]  din_data_p1, din_port_p1, alu_res_p1;
  logic               port_vld_p1;
  logic [DATA_W-1:0]  port_addr_p1, port_dat_p1;
  logic               c_q, z_q;
  logic [1:0]         stk_q [FLAG_DEPTH];
  logic [DEPTH_W-1:0] depth_q;
  logic               err_q;

  logic [DATA_W-1:0]  rs_val, rd2_val, op2_val, alu_res, wr_dat;
  logic [DATA_W:0]    alu_out;
  logic               alu_c, alu_z;
  logic               stk_full, stk_empty;
  logic [DEPTH_W-1:0] depth_m1;
  logic [IDX_W-1:0]   push_idx, pop_idx;
  logic [1:0]         pop_val;

  function automatic logic [DATA_W-1:0] read_reg(input logic [RSEL_W-1:0] sel);
    if (sel == '0 || int'(sel) >= NREGS) return '0;
    return regs[sel];
  endfunction

  // Returns {carry, result}; shifts/rotates report the last bit moved out as carry.
  function automatic logic [DATA_W:0] alu_f(input logic [3:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b,
                                            input logic ci,
                                            input logic [CNT_W-1:0] n);
    logic [DATA_W:0]     shl, shr;
    logic [2*DATA_W-1:0] rol, ror;
    logic [DATA_W:0]     r;
    shl = {1'b0, a} << n;
    shr = {a, 1'b0} >> n;
    rol = {a, a} << n;
    ror = {a, a} >> n;
    r   = '0;
    case (op)
      4'd0:    r = {1'b0, a} + {1'b0, b};
      4'd1:    r = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, ci};
      4'd2:    r = {1'b0, a} - {1'b0, b};
      4'd3:    r = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, ci};
      4'd4:    r = {1'b0, a & b};
      4'd5:    r = {1'b0, a | b};
      4'd6:    r = {1'b0, a ^ b};
      4'd7:    r = {1'b0, a & ~b};
      4'd8:    r = shl;
      4'd9:    r = {shr[0], shr[DATA_W:1]};
      4'd10:   r = {shl[DATA_W], rol[2*DATA_W-1:DATA_W]};
      4'd11:   r = {shr[0], ror[DATA_W-1:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    rs_val    = read_reg(rs_i);
    rd2_val   = dp_sel_i ? read_reg(rd_i) : read_reg(rs2_i);
    op2_val   = op2_sel_i ? immed_i : rd2_val;
    alu_out   = alu_f(alu_op_i, rs_val, op2_val, c_q, count_i);
    alu_res   = alu_out[DATA_W-1:0];
    alu_c     = alu_out[DATA_W];
    alu_z     = (alu_res == '0);
    stk_full  = (int'(depth_q) == FLAG_DEPTH);
    stk_empty = (depth_q == '0);
    depth_m1  = depth_q - DEPTH_W'(1);
    push_idx  = depth_q[IDX_W-1:0];
    pop_idx   = depth_m1[IDX_W-1:0];
    pop_val   = stk_empty ? 2'b00 : stk_q[pop_idx];
    case (reg_mux_i)
      2'b00:   wr_dat = alu_res_p1;
      2'b01:   wr_dat = din_data_p1;
      2'b10:   wr_dat = din_port_p1;
      default: wr_dat = '0;
    endcase
  end

  // Stage p1: register bank write and input/result capture registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      din_data_p1 <= '0;
      din_port_p1 <= '0;
      alu_res_p1  <= '0;
    end else if (cen_i) begin
      if (reg_we_i && rd_i != '0) regs[rd_i] <= wr_dat;
      din_data_p1 <= data_dat_i;
      din_port_p1 <= port_dat_i;
      if (alu_en_i) alu_res_p1 <= alu_res;
    end
  end

  // Stage p1: port write strobe travels with its address/data
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      port_vld_p1  <= 1'b0;
      port_addr_p1 <= '0;
      port_dat_p1  <= '0;
    end else begin
      port_vld_p1 <= cen_i & port_we_i;
      if (cen_i && port_we_i) begin
        port_addr_p1 <= alu_res;
        port_dat_p1  <= rd2_val;
      end
    end
  end

  // Flags and shadow stack; a simultaneous push wins over the pop but still flags an error.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      depth_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < FLAG_DEPTH; i++) stk_q[i] <= 2'b00;
    end else if (cen_i) begin
      if (int_entry_i) begin
        if (stk_full) begin
          err_q <= 1'b1;
        end else begin
          stk_q[push_idx] <= {c_q, z_q};
          depth_q         <= depth_q + DEPTH_W'(1);
        end
        if (reti_i) err_q <= 1'b1;
      end else if (reti_i) begin
        if (stk_empty) err_q <= 1'b1;
        else           depth_q <= depth_m1;
      end
      if (flag_we_i) begin
        c_q <= alu_c;
        z_q <= alu_z;
      end else if (reti_i && !int_entry_i) begin
        {c_q, z_q} <= pop_val;
      end
    end
  end

  assign data_addr_o = alu_res;
  assign data_wdat_o = rd2_val;
  assign port_we_o   = port_vld_p1;
  assign port_addr_o = port_addr_p1;
  assign port_dat_o  = port_dat_p1;
  assign cc_c_o      = c_q;
  assign cc_z_o      = z_q;
  assign stk_depth_o = depth_q;
  assign stk_err_o   = err_q;

endmodule
